// File: rtl/etrange_mem_pkg.sv
// Shared definitions for the dual-port frame RAM, its port-A writer and port-B stream reader.
package etrange_mem_pkg;

    localparam int unsigned ADDR_SIZE = 16;
    localparam int unsigned DATA_SIZE = 32;

    typedef logic [ADDR_SIZE-1:0] addr_t;
    typedef logic [DATA_SIZE-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } rd_state_t;

endpackage

// File: rtl/stream_fifo.sv
// Small prefetch FIFO: registered storage, push/pop in the same cycle, no push-to-head bypass.
module stream_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     not_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             not_empty_q, not_empty_d;
    logic             pop_ok;

    // Popping an empty FIFO is a no-op.
    assign pop_ok = pop && not_empty_q;

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop_ok);
        not_empty_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            not_empty_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            not_empty_q <= not_empty_d;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign not_empty = not_empty_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Port-B read initiator: turns a (base, len) burst into a valid/ready word stream,
// hiding RAM read latency behind a credit-limited prefetch FIFO.
module ram_stream_reader #(
    parameter int unsigned ADDR_SIZE  = etrange_mem_pkg::ADDR_SIZE,
    parameter int unsigned DATA_SIZE  = etrange_mem_pkg::DATA_SIZE,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] base_addr,
    input  logic [ADDR_SIZE-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_SIZE-1:0] addr_B,
    output logic                 r_e_B,
    input  logic [DATA_SIZE-1:0] data_out_B,
    output logic [DATA_SIZE-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready
);

    import etrange_mem_pkg::*;

    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 2;

    rd_state_t            state_q, state_d;
    logic [ADDR_SIZE-1:0] addr_B_q, addr_B_d;
    logic [ADDR_SIZE-1:0] next_addr_q, next_addr_d;
    logic [ADDR_SIZE-1:0] issue_rem_q, issue_rem_d;
    logic [ADDR_SIZE-1:0] deliver_rem_q, deliver_rem_d;
    logic                 r_e_B_q, r_e_B_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [RD_LAT-1:0]    vld_pipe_q, vld_pipe_d;

    logic [FCNT_W-1:0]    fifo_count;
    logic [DATA_SIZE-1:0] fifo_head;
    logic                 fifo_not_empty;
    logic                 push;
    logic                 pop;
    logic [CNT_W-1:0]     outstanding_c;
    logic                 can_issue_c;

    assign push = vld_pipe_q[RD_LAT-1];
    assign pop  = fifo_not_empty && m_ready;

    // Outstanding = buffered + in the RAM pipe + the read presented this cycle.
    // Pops are deliberately not credited, so the FIFO can never overflow.
    always_comb begin
        vld_pipe_d    = '0;
        vld_pipe_d[0] = r_e_B_q;
        outstanding_c = CNT_W'(fifo_count) + CNT_W'(r_e_B_q);
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
        end
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            outstanding_c = outstanding_c + CNT_W'(vld_pipe_q[i]);
        end
        can_issue_c = (outstanding_c < CNT_W'(FIFO_DEPTH));
    end

    always_comb begin
        state_d       = state_q;
        addr_B_d      = addr_B_q;
        next_addr_d   = next_addr_q;
        issue_rem_d   = issue_rem_q;
        deliver_rem_d = deliver_rem_q;
        r_e_B_d       = 1'b0;

        if (pop) begin
            deliver_rem_d = deliver_rem_q - ADDR_SIZE'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d       = ISSUE;
                        r_e_B_d       = 1'b1;
                        addr_B_d      = base_addr;
                        next_addr_d   = base_addr + ADDR_SIZE'(1);
                        issue_rem_d   = len - ADDR_SIZE'(1);
                        deliver_rem_d = len;
                    end
                end
            end
            ISSUE: begin
                // issue_rem_q counts reads still to be presented after the current one.
                if (issue_rem_q != '0) begin
                    if (can_issue_c) begin
                        r_e_B_d     = 1'b1;
                        addr_B_d    = next_addr_q;
                        next_addr_d = next_addr_q + ADDR_SIZE'(1);
                        issue_rem_d = issue_rem_q - ADDR_SIZE'(1);
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (deliver_rem_q == ADDR_SIZE'(1))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == ISSUE) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            addr_B_q      <= '0;
            next_addr_q   <= '0;
            issue_rem_q   <= '0;
            deliver_rem_q <= '0;
            r_e_B_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            vld_pipe_q    <= '0;
        end else begin
            state_q       <= state_d;
            addr_B_q      <= addr_B_d;
            next_addr_q   <= next_addr_d;
            issue_rem_q   <= issue_rem_d;
            deliver_rem_q <= deliver_rem_d;
            r_e_B_q       <= r_e_B_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            vld_pipe_q    <= vld_pipe_d;
        end
    end

    stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_SIZE)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (data_out_B),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .not_empty (fifo_not_empty)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign addr_B  = addr_B_q;
    assign r_e_B   = r_e_B_q;
    assign m_data  = fifo_head;
    assign m_valid = fifo_not_empty;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed and randomized bursts against a RAM model; expected stream derived from (base, len) and RAM contents.
module tb_ram_stream_reader;

    import etrange_mem_pkg::*;

    localparam int FD = 4;

    logic  clk = 1'b0;
    logic  reset_n = 1'b0;
    logic  start = 1'b0;
    addr_t base_addr = '0;
    addr_t len = '0;
    logic  busy, done, r_e_B, m_valid;
    logic  m_ready = 1'b0;
    addr_t addr_B;
    data_t data_out_B;
    data_t m_data;

    data_t ram [0:65535];

    always #5 clk = ~clk;

    // Port-B RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (r_e_B) data_out_B <= ram[addr_B];
    end

    ram_stream_reader #(
        .ADDR_SIZE  (ADDR_SIZE),
        .DATA_SIZE  (DATA_SIZE),
        .RD_LAT     (1),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .addr_B     (addr_B),
        .r_e_B      (r_e_B),
        .data_out_B (data_out_B),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
    );

    int    tests = 0;
    int    fails = 0;
    data_t exp_q[$];
    addr_t exp_addr[$];
    int    issued, accepted, done_cnt, cyc, first_re, first_v, last_acc, rdy_mode;
    logic  prev_stall;
    data_t prev_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-cycle observation at the falling edge.
    task automatic observe();
        cyc++;
        if (r_e_B) begin
            if (first_re < 0) first_re = cyc;
            check("read_expected", 32'(exp_addr.size() != 0), 32'd1);
            if (exp_addr.size() != 0) check("addr_B", 32'(addr_B), 32'(exp_addr.pop_front()));
            check("credit", 32'((issued - accepted) < FD), 32'd1);
            issued++;
        end
        if (m_valid && first_v < 0) first_v = cyc;
        if (prev_stall) begin
            check("stall_valid", 32'(m_valid), 32'd1);
            check("stall_data", m_data, prev_data);
        end
        if (m_valid && m_ready) begin
            check("word_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("m_data", m_data, exp_q.pop_front());
            accepted++;
            last_acc = cyc;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        if (done) begin
            done_cnt++;
            check("busy_at_done", 32'(busy), 32'd0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        observe();
    endtask

    task automatic new_burst(input addr_t b, input int l);
        addr_t a;
        exp_q.delete();
        exp_addr.delete();
        for (int i = 0; i < l; i++) begin
            a = b + addr_t'(i);
            exp_addr.push_back(a);
            exp_q.push_back(ram[a]);
        end
        issued = 0; accepted = 0; done_cnt = 0;
        first_re = -1; first_v = -1; last_acc = -1;
    endtask

    task automatic run_burst(input addr_t b, input int l, input int mode, input int inj);
        new_burst(b, l);
        rdy_mode = mode;
        start = 1'b1; base_addr = b; len = addr_t'(l);
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        for (int n = 0; n < 400 && done_cnt == 0; n++) begin
            if (n == inj) begin
                start = 1'b1; base_addr = 16'd100; len = 16'd2;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check("done_seen", 32'(done_cnt), 32'd1);
        check("words", 32'(accepted), 32'(l));
        check("reads", 32'(issued), 32'(l));
        check("exp_left", 32'(exp_q.size()), 32'd0);
        for (int n = 0; n < 3; n++) tick();
        check("done_once", 32'(done_cnt), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int rb, rl;
        for (int i = 0; i < 65536; i++) ram[i] = $urandom;
        for (int i = 0; i < 8; i++) ram[i] = 32'(245 + i);
        cyc = 0; rdy_mode = 0; prev_stall = 1'b0; prev_data = '0;
        new_burst(16'd0, 0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_re", 32'(r_e_B), 32'd0);
        check("rst_addr", 32'(addr_B), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", m_data, 32'd0);
        reset_n = 1'b1;

        // Basic burst: latency and throughput
        run_burst(16'd0, 8, 0, -1);
        check("fill_latency", 32'(first_v - first_re), 32'd2);
        check("throughput", 32'(last_acc - first_v), 32'd7);

        // Back-pressure 1,0,0,1
        run_burst(16'd0, 6, 1, -1);

        // Address wrap
        run_burst(16'hFFFE, 4, 0, -1);

        // Zero length
        new_burst(16'd5, 0);
        rdy_mode = 0;
        start = 1'b1; base_addr = 16'd5; len = 16'd0;
        tick();
        start = 1'b0;
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        tick();
        check("zero_done_end", 32'(done), 32'd0);
        check("zero_busy2", 32'(busy), 32'd0);
        check("zero_done_cnt", 32'(done_cnt), 32'd1);

        // Start while busy is ignored
        run_burst(16'd20, 8, 0, 2);

        // Randomized bursts
        for (int k = 0; k < 4; k++) begin
            rb = int'($urandom_range(0, 65535));
            rl = int'($urandom_range(1, 20));
            run_burst(addr_t'(rb), rl, 2, -1);
        end

        // Reset mid-burst
        new_burst(16'd0, 8);
        rdy_mode = 0;
        start = 1'b1; base_addr = 16'd0; len = 16'd8;
        tick();
        start = 1'b0;
        for (int n = 0; n < 100 && accepted < 3; n++) tick();
        check("pre_reset_words", 32'(accepted), 32'd3);
        @(negedge clk);
        reset_n = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete(); exp_addr.delete();
        done_cnt = 0; prev_stall = 1'b0;
        check("abort_valid", 32'(m_valid), 32'd0);
        check("abort_re", 32'(r_e_B), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_data", m_data, 32'd0);
        for (int n = 0; n < 4; n++) tick();
        check("abort_no_done", 32'(done_cnt), 32'd0);

        ram[1] = 32'd420;
        run_burst(16'd1, 1, 0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side initiator for the dual-port frame RAM: drives read port B (addr_B, r_e_B) and consumes data_out_B.
- Converts a (base, length) burst request into a valid/ready word stream for downstream pixel-processing blocks.
- Pairs with the RAM's port-A writer. Hides RAM read latency behind a small prefetch FIFO and tolerates arbitrary consumer back-pressure.

Parameters:
- ADDR_SIZE, 16, RAM address width; also the width of the burst length.
- DATA_SIZE, 32, RAM word width.
- RD_LAT, 1, RAM port-B read latency in cycles (legal values 1..2).
- FIFO_DEPTH, 4, prefetch FIFO entries (power of 2, at least RD_LAT+2).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous reset, active low.
- start  in  1  burst request; sampled only while busy=0.
- base_addr  in  ADDR_SIZE  first RAM word address; captured with start.
- len  in  ADDR_SIZE  number of words to read; captured with start.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse after the last word is accepted downstream.
- addr_B  out  ADDR_SIZE  RAM port-B address.
- r_e_B  out  1  RAM port-B read enable.
- data_out_B  in  DATA_SIZE  RAM port-B read data; valid RD_LAT cycles after r_e_B.
- m_data  out  DATA_SIZE  stream data.
- m_valid  out  1  stream data valid.
- m_ready  in  1  consumer ready.

Behaviour:
- Reset: synchronous, active-low; one clock is enough.
  - Outputs after reset: busy=0, done=0, r_e_B=0, addr_B=0, m_valid=0, m_data=0.
  - FIFO, in-flight pipe and counters are cleared.
  - Reset mid-burst aborts the burst, discards in-flight words and produces no done pulse.
- FSM states and transitions:
  - IDLE -> ISSUE when start=1 and len!=0. base_addr and len are latched; busy=1 from the next cycle.
  - IDLE -> DONE when start=1 and len==0. No RAM reads are issued.
  - ISSUE -> DRAIN in the cycle the len-th read is issued.
  - DRAIN -> DONE when the last word completes the m_valid&&m_ready handshake.
  - DONE -> IDLE after exactly one cycle. done=1 only in DONE; busy=0 in DONE and IDLE.
- start while busy=1 is ignored. start in the DONE cycle is also ignored.
- Issue rule: r_e_B=1 in ISSUE only if (fifo_count + inflight) < FIFO_DEPTH.
  - Conservative credit: a same-cycle FIFO pop does not count toward the credit check.
  - Each issue: addr_B = current address, then address increments by 1 and issued count increments by 1.
- Address arithmetic is ADDR_SIZE bits and wraps from 2^ADDR_SIZE-1 to 0. Wrap is not an error.
- addr_B holds its last value when r_e_B=0.
- In-flight tracking: an RD_LAT-deep valid shift register. data_out_B is pushed into the FIFO when the valid bit emerges. The credit rule guarantees the FIFO never overflows; the push is unconditional.
- Stream output:
  - m_valid = FIFO not empty; m_data = FIFO head.
  - m_data and m_valid stay stable while m_valid=1 and m_ready=0.
  - Simultaneous push and pop in one cycle is supported.
- Latency (RD_LAT=1):
  - start sampled at edge E0 -> r_e_B=1, addr_B=base during E0..E1.
  - Data captured at E2 -> m_valid=1 after E2, i.e. 2 cycles after the first r_e_B.
- Throughput: with m_ready held at 1, one word per cycle after the fill latency.
- done asserts the cycle after the final handshake edge.

Decomposition:
- Package etrange_mem_pkg:
  - ADDR_SIZE and DATA_SIZE constants.
  - typedefs addr_t and data_t.
  - enum rd_state_t {IDLE, ISSUE, DRAIN, DONE}.
  - This package is shared with the RAM and the port-A writer.
- Sub-module stream_fifo (parameters DEPTH and WIDTH): push, pop, count, head data; no internal bypass.
- ram_stream_reader holds the FSM, counters, issue logic and in-flight pipe.

Test Plan:
- Basic burst: RAM preloaded with words 0..7 = 245+i; start, base=0, len=8, m_ready=1.
  - m_data sequence 245..252, one per cycle.
  - First m_valid 2 cycles after the first r_e_B.
  - done pulses once; busy falls with done.
- Back-pressure: len=6, m_ready toggling 1,0,0,1.
  - No word lost or duplicated; m_data stable while stalled.
  - r_e_B deasserts whenever fifo_count+inflight reaches 4.
- Address wrap: base=16'hFFFE, len=4.
  - addr_B sequence FFFE, FFFF, 0000, 0001; data matches RAM contents.
- Zero length: start with len=0.
  - r_e_B never asserts; done pulses 1 cycle after start; busy stays 0.
- Start while busy: second start (base=100, len=2) mid-burst.
  - It is ignored; exactly one done; word count equals the first len only.
- Reset mid-burst: reset_n=0 for one cycle after 3 of 8 words are delivered.
  - Next cycle: m_valid=0, r_e_B=0, busy=0, no done.
  - A new burst (data 420 at addr 1, base=1, len=1) delivers 420 correctly.
